codificador_4_2_reg: RTL and testbench
======================================

Name: codificador_4_2_reg

Overview:
- Registered 4→2 encoder. It is the return path of the 2→4 decoder: it takes the decoder-style scalar lines Y0..Y3 and recovers the address A,B.
- A presence flag V and a non-one-hot error flag ERR accompany each result.
- Results sit in a 1-entry output buffer with a valid/ready handshake, so the block can feed a slower consumer in the lab datapath.
- Also recomputes f2 = ~B and f3 = ~C·(A⊕B) from the encoded address, as a cross-check against the decoder-side functions.

Parameters:
- PRIO_ALTA, 1: 1 → Y3 has highest priority; 0 → Y0 has highest priority.
- W_CONT, 8: width of the saturating error counter (valid range 2..16).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Y0  input  1  line for address AB=00.
- Y1  input  1  line for address AB=01.
- Y2  input  1  line for address AB=10.
- Y3  input  1  line for address AB=11.
- C  input  1  auxiliary input for f3, captured with Y0..Y3.
- in_valid  input  1  Y0..Y3,C are presented this cycle.
- in_ready  output  1  block can accept this cycle.
- A  output  1  encoded MSB (registered).
- B  output  1  encoded LSB (registered).
- V  output  1  at least one Y line was active in the captured word.
- ERR  output  1  more than one Y line was active in the captured word.
- f2  output  1  ~B of the buffered result, gated by V.
- f3  output  1  ~C_cap & (A^B) of the buffered result, gated by V.
- out_valid  output  1  buffer holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- err_cont  output  W_CONT  saturating count of accepted words with ERR=1.

Behaviour:
- Reset (rst=1, asynchronous): A=B=V=ERR=0, C_cap=0, out_valid=0, state=VAZIO, err_cont=0. in_ready=1 only after reset is released.
- Reset mid-transfer discards any buffered result. No handshake completes in the cycle rst is high.
- FSM has two states:
  - VAZIO: out_valid=0.
  - CHEIO: out_valid=1.
- in_ready = ~rst & (state==VAZIO | out_ready). This allows a combinational pass-through of ready, so a full buffer can refill in the same cycle it drains.
- Accept = in_valid & in_ready.
- Drain = out_valid & out_ready.
- State transitions:
  - VAZIO, accept → CHEIO.
  - CHEIO, drain & ~accept → VAZIO.
  - CHEIO, drain & accept → stays CHEIO with the new data.
  - CHEIO, ~drain → holds. A, B, V, ERR, f2, f3 stay stable while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1).
- Encoding on accept:
  - With PRIO_ALTA=1, the highest active index wins: Y3→11, Y2→10, Y1→01, Y0→00.
  - With PRIO_ALTA=0, the lowest active index wins.
  - No line active: AB=00, V=0, ERR=0.
  - V = Y0|Y1|Y2|Y3.
  - ERR = 1 when two or more lines are active.
- f2 = V & ~B; f3 = V & ~C_cap & (A^B). Both are combinational from registers and are 0 when V=0.
- err_cont increments by 1 on each accept with ERR=1 and saturates at 2^W_CONT−1 (no wrap).
- in_valid=0 causes no state change. Inputs are ignored when not accepted.

Optional Feature:
- Macro: CODIF_CONT_ERRO_EN.
- Defined: err_cont counter is implemented as described.
- Undefined: no counter register is built; err_cont is tied to 0. All other behaviour is identical.

Test Plan:
- Reset release, then in_valid=1, Y2=1 (others 0), C=0, out_ready=1 → next cycle out_valid=1, A=1, B=0, V=1, ERR=0, f2=1, f3=1.
- Y1=Y3=1 with PRIO_ALTA=1 → AB=11, ERR=1, err_cont=1. Same stimulus with PRIO_ALTA=0 → AB=01, ERR=1.
- All Y=0, in_valid=1 → AB=00, V=0, ERR=0, f2=0, f3=0, out_valid=1.
- Backpressure:
  - Accept Y0=1, then hold out_ready=0 for 3 cycles while presenting Y3=1 → in_ready=0, outputs stay AB=00.
  - Then out_ready=1 → Y3 word accepted in the drain cycle; next cycle AB=11, out_valid=1.
- With W_CONT=2 and CODIF_CONT_ERRO_EN defined, 5 accepted words with ERR=1 → err_cont saturates at 3.
- Assert rst mid-cycle while out_valid=1 → out_valid, A, B, V, ERR, err_cont go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/codificador_4_2_reg.sv
// Registered 4->2 priority encoder with presence/error flags and a 1-entry valid/ready output buffer.
// Optional saturating error counter enabled by defining CODIF_CONT_ERRO_EN.
module codificador_4_2_reg #(
  parameter int unsigned PRIO_ALTA = 1,
  parameter int unsigned W_CONT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Y0,
  input  logic              Y1,
  input  logic              Y2,
  input  logic              Y3,
  input  logic              C,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              A,
  output logic              B,
  output logic              V,
  output logic              ERR,
  output logic              f2,
  output logic              f3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_CONT-1:0] err_cont
);

  localparam int unsigned W_IDX = 2;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  estado_t          state_q, state_d;
  logic [3:0]       y_c;
  logic [W_IDX-1:0] idx_c;
  logic             pres_c;
  logic             multi_c;
  logic             accept_c;
  logic             drain_c;

  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             v_q, v_d;
  logic             err_q, err_d;
  logic             c_q, c_d;

  assign y_c = {Y3, Y2, Y1, Y0};

  // Priority encode; PRIO_ALTA selects whether the highest or lowest active line wins.
  always_comb begin
    idx_c = W_IDX'(0);
    if (PRIO_ALTA != 0) begin
      casez (y_c)
        4'b1???: idx_c = W_IDX'(3);
        4'b01??: idx_c = W_IDX'(2);
        4'b001?: idx_c = W_IDX'(1);
        default: idx_c = W_IDX'(0);
      endcase
    end else begin
      casez (y_c)
        4'b???1: idx_c = W_IDX'(0);
        4'b??10: idx_c = W_IDX'(1);
        4'b?100: idx_c = W_IDX'(2);
        4'b1000: idx_c = W_IDX'(3);
        default: idx_c = W_IDX'(0);
      endcase
    end
  end

  // Clearing the lowest set bit leaves something only if two or more lines are active.
  assign pres_c  = |y_c;
  assign multi_c = |(y_c & (y_c - 4'd1));

  // Ready passes through from the consumer so a full buffer refills while draining.
  assign in_ready = ~rst & ((state_q == VAZIO) | out_ready);
  assign accept_c = in_valid & in_ready;
  assign drain_c  = (state_q == CHEIO) & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VAZIO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VAZIO: begin
        if (accept_c) begin
          state_d = CHEIO;
        end
      end
      CHEIO: begin
        if (drain_c && !accept_c) begin
          state_d = VAZIO;
        end
      end
      default: state_d = VAZIO;
    endcase
  end

  // Result registers load only on accept, so they hold under backpressure.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    v_d   = v_q;
    err_d = err_q;
    c_d   = c_q;
    if (accept_c) begin
      a_d   = idx_c[1];
      b_d   = idx_c[0];
      v_d   = pres_c;
      err_d = multi_c;
      c_d   = C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      v_q   <= 1'b0;
      err_q <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      v_q   <= v_d;
      err_q <= err_d;
      c_q   <= c_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign V         = v_q;
  assign ERR       = err_q;
  assign out_valid = (state_q == CHEIO);
  assign f2        = v_q & ~b_q;
  assign f3        = v_q & ~c_q & (a_q ^ b_q);

`ifdef CODIF_CONT_ERRO_EN
  logic [W_CONT-1:0] cnt_q, cnt_d;

  // Saturating count of accepted multi-hot words.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c && multi_c && (cnt_q != {W_CONT{1'b1}})) begin
      cnt_d = cnt_q + W_CONT'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cont = cnt_q;
`else
  assign err_cont = '0;
`endif

endmodule

// File: tb/tb_codificador_4_2_reg.sv
// Bench for codificador_4_2_reg: two instances (high/low priority, W_CONT=8/2) against a behavioural model.
module tb_codificador_4_2_reg;

  logic clk = 1'b0;
  logic rst;
  logic y0, y1, y2, y3, c, in_valid, out_ready;

  logic       rdy_h, a_h, b_h, v_h, e_h, f2_h, f3_h, ov_h;
  logic [7:0] cnt_h;
  logic       rdy_l, a_l, b_l, v_l, e_l, f2_l, f3_l, ov_l;
  logic [1:0] cnt_l;

  int n_cmp = 0;
  int n_err = 0;

  // Model state, index 0 = PRIO_ALTA=1/W_CONT=8, index 1 = PRIO_ALTA=0/W_CONT=2
  bit m_full[2], m_a[2], m_b[2], m_v[2], m_e[2], m_c[2];
  int m_cnt[2];
  int prio[2] = '{1, 0};
  int cmax[2] = '{255, 3};

  always #5 clk = ~clk;

  codificador_4_2_reg #(.PRIO_ALTA(1), .W_CONT(8)) dut_h (
    .clk(clk), .rst(rst), .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3), .C(c),
    .in_valid(in_valid), .in_ready(rdy_h), .A(a_h), .B(b_h), .V(v_h), .ERR(e_h),
    .f2(f2_h), .f3(f3_h), .out_valid(ov_h), .out_ready(out_ready), .err_cont(cnt_h)
  );

  codificador_4_2_reg #(.PRIO_ALTA(0), .W_CONT(2)) dut_l (
    .clk(clk), .rst(rst), .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3), .C(c),
    .in_valid(in_valid), .in_ready(rdy_l), .A(a_l), .B(b_l), .V(v_l), .ERR(e_l),
    .f2(f2_l), .f3(f3_l), .out_valid(ov_l), .out_ready(out_ready), .err_cont(cnt_l)
  );

  function automatic void encode(input int p, input bit [3:0] y,
                                 output bit a, output bit b, output bit v, output bit e);
    int idx = 0;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) begin
        n++;
        if (p == 1 || n == 1) idx = i;
      end
    end
    a = (idx / 2) != 0;
    b = (idx % 2) != 0;
    v = n > 0;
    e = n > 1;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int k);
`ifdef CODIF_CONT_ERRO_EN
    return m_cnt[k];
`else
    return 0 * k;
`endif
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "/h.out_valid"}, 16'(ov_h), 16'(m_full[0]));
    check({tag, "/h.AB"}, 16'({a_h, b_h}), 16'({m_a[0], m_b[0]}));
    check({tag, "/h.V"}, 16'(v_h), 16'(m_v[0]));
    check({tag, "/h.ERR"}, 16'(e_h), 16'(m_e[0]));
    check({tag, "/h.f2"}, 16'(f2_h), 16'(m_v[0] & ~m_b[0]));
    check({tag, "/h.f3"}, 16'(f3_h), 16'(m_v[0] & ~m_c[0] & (m_a[0] ^ m_b[0])));
    check({tag, "/h.err_cont"}, 16'(cnt_h), 16'(exp_cnt(0)));
    check({tag, "/l.out_valid"}, 16'(ov_l), 16'(m_full[1]));
    check({tag, "/l.AB"}, 16'({a_l, b_l}), 16'({m_a[1], m_b[1]}));
    check({tag, "/l.V"}, 16'(v_l), 16'(m_v[1]));
    check({tag, "/l.ERR"}, 16'(e_l), 16'(m_e[1]));
    check({tag, "/l.f2"}, 16'(f2_l), 16'(m_v[1] & ~m_b[1]));
    check({tag, "/l.f3"}, 16'(f3_l), 16'(m_v[1] & ~m_c[1] & (m_a[1] ^ m_b[1])));
    check({tag, "/l.err_cont"}, 16'(cnt_l), 16'(exp_cnt(1)));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_a[k] = 0; m_b[k] = 0; m_v[k] = 0; m_e[k] = 0; m_c[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One cycle: check registered outputs, drive inputs, check ready, advance model past next edge.
  task automatic step(input string tag, input bit [3:0] y, input bit cc, input bit iv, input bit ordy);
    bit rdy, acc, a, b, v, e;
    @(negedge clk);
    check_outs(tag);
    {y3, y2, y1, y0} = y;
    c = cc;
    in_valid = iv;
    out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy = !m_full[k] || ordy;
      if (k == 0) check({tag, "/h.in_ready"}, 16'(rdy_h), 16'(rdy));
      else        check({tag, "/l.in_ready"}, 16'(rdy_l), 16'(rdy));
      acc = iv && rdy;
      if (acc) begin
        encode(prio[k], y, a, b, v, e);
        m_a[k] = a; m_b[k] = b; m_v[k] = v; m_e[k] = e; m_c[k] = cc;
        m_full[k] = 1;
        if (e && m_cnt[k] < cmax[k]) m_cnt[k]++;
      end else if (m_full[k] && ordy) begin
        m_full[k] = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {y3, y2, y1, y0} = 4'b0;
    c = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    check("reset/h.in_ready", 16'(rdy_h), 16'(0));
    rst = 1'b0;

    step("y2_accept", 4'b0100, 1'b0, 1'b1, 1'b1);
    step("y1y3_multi", 4'b1010, 1'b1, 1'b1, 1'b1);
    step("none_active", 4'b0000, 1'b0, 1'b1, 1'b1);
    step("after_none", 4'b0000, 1'b0, 1'b0, 1'b1);

    step("bp_y0", 4'b0001, 1'b1, 1'b1, 1'b1);
    repeat (3) step("bp_hold", 4'b1000, 1'b0, 1'b1, 1'b0);
    step("bp_drain_refill", 4'b1000, 1'b0, 1'b1, 1'b1);
    step("bp_y3_seen", 4'b0000, 1'b0, 1'b0, 1'b0);
    step("bp_idle", 4'b0000, 1'b0, 1'b0, 1'b1);

    repeat (5) step("sat", 4'b1010, 1'b0, 1'b1, 1'b1);
    step("sat_seen", 4'b0110, 1'b1, 1'b1, 1'b0);
    step("full_hold", 4'b0001, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while the buffer is full.
    @(negedge clk);
    check_outs("pre_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs("async_rst");
    check("async_rst/h.in_ready", 16'(rdy_h), 16'(0));
    check("async_rst/l.in_ready", 16'(rdy_l), 16'(0));
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_outs("rst_held");
    rst = 1'b0;
    in_valid = 1'b0;

    for (int i = 0; i < 400; i++) begin
      step("rand", 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    step("final", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
